// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage
// MEM->WB pipeline register with a valid/ready handshake, an optional
// second (skid) entry, synchronous flush and a forwarding tap that
// remembers the most recently retired register-file write.
module mem_wb_pipe_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SKID_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [1:0]            occupancy
);

  localparam bit SKID_ON = (SKID_EN != 0);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  occ_state_e state_q, state_d;

  logic accept;
  logic retire;
  logic cap_reg_write;
  logic load_main_from_in;
  logic load_main_from_skid;
  logic load_skid;

  logic [DATA_W-1:0]     main_data_q, skid_data_q;
  logic [REG_ADDR_W-1:0] main_rd_q,   skid_rd_q;
  logic                  main_rw_q,   skid_rw_q;

  // Writes to x0 are architecturally meaningless, so they are squashed on capture
  assign accept        = in_valid & in_ready;
  assign retire        = out_valid & out_ready;
  assign cap_reg_write = in_reg_write & (in_rd != '0);

  // Occupancy state register; reset empties the stage immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: flush wins, otherwise count accepts in and retires out
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (accept) state_d = OCC_ONE;
        OCC_ONE: begin
          if (accept && !retire) begin
            if (SKID_ON) state_d = OCC_TWO;
          end else if (retire && !accept) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO:   if (retire) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // Handshake outputs; with the skid entry in_ready depends on registered state only
  always_comb begin
    out_valid = (state_q != OCC_EMPTY);
    occupancy = state_q;
    if (SKID_ON) begin
      in_ready = (state_q != OCC_TWO);
    end else begin
      in_ready = (state_q == OCC_EMPTY) | out_ready;
    end
  end

  // Decide which entry is written this cycle; a flush suppresses every load
  always_comb begin
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    if (!flush) begin
      load_main_from_in   = accept & ((state_q == OCC_EMPTY) | retire);
      load_skid           = SKID_ON & accept & (state_q == OCC_ONE) & ~retire;
      load_main_from_skid = retire & (state_q == OCC_TWO);
    end
  end

  // MAIN entry drives out_* and simply holds its value when it goes invalid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_rw_q   <= 1'b0;
    end else if (load_main_from_in) begin
      main_data_q <= in_data;
      main_rd_q   <= in_rd;
      main_rw_q   <= cap_reg_write;
    end else if (load_main_from_skid) begin
      main_data_q <= skid_data_q;
      main_rd_q   <= skid_rd_q;
      main_rw_q   <= skid_rw_q;
    end
  end

  // SKID entry catches the word that arrives while MAIN is stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_rw_q   <= 1'b0;
    end else if (load_skid) begin
      skid_data_q <= in_data;
      skid_rd_q   <= in_rd;
      skid_rw_q   <= cap_reg_write;
    end
  end

  // Forwarding tap records every retired register write, even during a flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
    end else if (retire && main_rw_q) begin
      fwd_valid <= 1'b1;
      fwd_rd    <= main_rd_q;
      fwd_data  <= main_data_q;
    end
  end

  assign out_data      = main_data_q;
  assign out_rd        = main_rd_q;
  assign out_reg_write = main_rw_q;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb_mem_wb_pipe_stage
// Drives a skid build and a single-entry build with identical inputs and
// compares both against a FIFO-style reference model, plus a table of
// hand-derived expectations for the skid build.
module tb_mem_wb_pipe_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, flush, in_valid, in_reg_write, out_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_rd;

  logic          ird_s, ov_s, orw_s, fv_s, ird_n, ov_n, orw_n, fv_n;
  logic [DW-1:0] od_s, fd_s, od_n, fd_n;
  logic [AW-1:0] ord_s, frd_s, ord_n, frd_n;
  logic [1:0]    occ_s, occ_n;

  mem_wb_pipe_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .SKID_EN(1)) dut_skid (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ird_s), .in_data(in_data), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .out_valid(ov_s), .out_ready(out_ready),
    .out_data(od_s), .out_rd(ord_s), .out_reg_write(orw_s),
    .fwd_valid(fv_s), .fwd_rd(frd_s), .fwd_data(fd_s), .occupancy(occ_s)
  );

  mem_wb_pipe_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .SKID_EN(0)) dut_noskid (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ird_n), .in_data(in_data), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .out_valid(ov_n), .out_ready(out_ready),
    .out_data(od_n), .out_rd(ord_n), .out_reg_write(orw_n),
    .fwd_valid(fv_n), .fwd_rd(frd_n), .fwd_data(fd_n), .occupancy(occ_n)
  );

  typedef struct packed {
    logic          ov;
    logic [1:0]    occ;
    logic          ird;
    logic [DW-1:0] od;
    logic [AW-1:0] ord;
    logic          orw;
    logic          fv;
    logic [AW-1:0] frd;
    logic [DW-1:0] fd;
  } obs_t;

  obs_t obs_s, obs_n;
  assign obs_s = {ov_s, occ_s, ird_s, od_s, ord_s, orw_s, fv_s, frd_s, fd_s};
  assign obs_n = {ov_n, occ_n, ird_n, od_n, ord_n, orw_n, fv_n, frd_n, fd_n};

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          rw;
  } pl_t;

  typedef struct {
    logic          f, v;
    logic [DW-1:0] d;
    logic [AW-1:0] r;
    logic          w, ordy;
    obs_t          exp;
  } vec_t;

  // Reference model: index 0 = two-deep stage, index 1 = one-deep stage
  pl_t           fifo [2][2];
  int            cnt [2];
  pl_t           shown [2];
  logic          m_fv [2];
  logic [AW-1:0] m_frd [2];
  logic [DW-1:0] m_fd [2];

  int n_vec  = 0;
  int n_fail = 0;

  vec_t vecs[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      cnt[m]   = 0;
      shown[m] = '0;
      m_fv[m]  = 1'b0;
      m_frd[m] = '0;
      m_fd[m]  = '0;
    end
  endtask

  function automatic logic modelReady(input int m);
    if (m == 0) return (cnt[0] < 2);
    return (cnt[1] == 0) || (out_ready == 1'b1);
  endfunction

  task automatic modelStep();
    logic acc, ret;
    pl_t  cap;
    for (int m = 0; m < 2; m++) begin
      acc = in_valid && modelReady(m);
      ret = (cnt[m] > 0) && out_ready;
      cap.data = in_data;
      cap.rd   = in_rd;
      cap.rw   = in_reg_write && (in_rd != 0);
      if (ret) begin
        if (fifo[m][0].rw) begin
          m_fv[m]  = 1'b1;
          m_frd[m] = fifo[m][0].rd;
          m_fd[m]  = fifo[m][0].data;
        end
        fifo[m][0] = fifo[m][1];
        cnt[m]--;
      end
      if (flush) cnt[m] = 0;
      else if (acc) begin
        fifo[m][cnt[m]] = cap;
        cnt[m]++;
      end
      if (cnt[m] > 0) shown[m] = fifo[m][0];
    end
  endtask

  function automatic obs_t modelObs(input int m);
    obs_t o;
    o.ov  = (cnt[m] > 0);
    o.occ = 2'(cnt[m]);
    o.ird = modelReady(m);
    o.od  = shown[m].data;
    o.ord = shown[m].rd;
    o.orw = shown[m].rw;
    o.fv  = m_fv[m];
    o.frd = m_frd[m];
    o.fd  = m_fd[m];
    return o;
  endfunction

  task automatic compareObs(input string tag, input obs_t a, input obs_t e);
    cmp({tag, ".out_valid"},     64'(a.ov),  64'(e.ov));
    cmp({tag, ".occupancy"},     64'(a.occ), 64'(e.occ));
    cmp({tag, ".in_ready"},      64'(a.ird), 64'(e.ird));
    cmp({tag, ".out_data"},      64'(a.od),  64'(e.od));
    cmp({tag, ".out_rd"},        64'(a.ord), 64'(e.ord));
    cmp({tag, ".out_reg_write"}, 64'(a.orw), 64'(e.orw));
    cmp({tag, ".fwd_valid"},     64'(a.fv),  64'(e.fv));
    cmp({tag, ".fwd_rd"},        64'(a.frd), 64'(e.frd));
    cmp({tag, ".fwd_data"},      64'(a.fd),  64'(e.fd));
  endtask

  task automatic checkOutput();
    compareObs("skid",   obs_s, modelObs(0));
    compareObs("noskid", obs_n, modelObs(1));
  endtask

  task automatic applyStimulus(input logic f, input logic v, input logic [DW-1:0] d,
                               input logic [AW-1:0] r, input logic w, input logic ordy);
    flush        = f;
    in_valid     = v;
    in_data      = d;
    in_rd        = r;
    in_reg_write = w;
    out_ready    = ordy;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  function automatic vec_t mk(input logic f, input logic v, input logic [DW-1:0] d,
                              input logic [AW-1:0] r, input logic w, input logic ordy,
                              input logic ov, input logic [1:0] occ, input logic ird,
                              input logic [DW-1:0] od, input logic [AW-1:0] ord,
                              input logic orw, input logic fv, input logic [AW-1:0] frd,
                              input logic [DW-1:0] fd);
    vec_t x;
    x.f = f; x.v = v; x.d = d; x.r = r; x.w = w; x.ordy = ordy;
    x.exp = {ov, occ, ird, od, ord, orw, fv, frd, fd};
    return x;
  endfunction

  initial begin
    // Expected state of the two-deep build after each row's clock edge
    //          f  v  data      rd  w  ordy  ov occ ird out_data  rd  rw  fv frd fwd_data
    vecs.push_back(mk(0, 1, 32'h11,    5, 1, 1,   1, 1, 1, 32'h11,    5, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h22,    6, 1, 1,   1, 1, 1, 32'h22,    6, 1, 1, 5, 32'h11));
    vecs.push_back(mk(0, 1, 32'h33,    7, 1, 1,   1, 1, 1, 32'h33,    7, 1, 1, 6, 32'h22));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,   0, 0, 1, 32'h33,    7, 1, 1, 7, 32'h33));
    vecs.push_back(mk(0, 1, 32'hA1,    3, 1, 0,   1, 1, 1, 32'hA1,    3, 1, 1, 7, 32'h33));
    vecs.push_back(mk(0, 1, 32'hA2,    4, 1, 0,   1, 2, 0, 32'hA1,    3, 1, 1, 7, 32'h33));
    vecs.push_back(mk(0, 1, 32'hA3,    8, 1, 0,   1, 2, 0, 32'hA1,    3, 1, 1, 7, 32'h33));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,   1, 1, 1, 32'hA2,    4, 1, 1, 3, 32'hA1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,   0, 0, 1, 32'hA2,    4, 1, 1, 4, 32'hA2));
    vecs.push_back(mk(0, 1, 32'hDEAD,  0, 1, 0,   1, 1, 1, 32'hDEAD,  0, 0, 1, 4, 32'hA2));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,   0, 0, 1, 32'hDEAD,  0, 0, 1, 4, 32'hA2));
    vecs.push_back(mk(0, 1, 32'h1234,  9, 1, 0,   1, 1, 1, 32'h1234,  9, 1, 1, 4, 32'hA2));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,   0, 0, 1, 32'h1234,  9, 1, 1, 9, 32'h1234));
    vecs.push_back(mk(0, 1, 32'hB1,   10, 1, 0,   1, 1, 1, 32'hB1,   10, 1, 1, 9, 32'h1234));
    vecs.push_back(mk(0, 1, 32'hB2,   11, 1, 0,   1, 2, 0, 32'hB1,   10, 1, 1, 9, 32'h1234));
    vecs.push_back(mk(1, 1, 32'hB3,   12, 1, 0,   0, 0, 1, 32'hB1,   10, 1, 1, 9, 32'h1234));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,   0, 0, 1, 32'hB1,   10, 1, 1, 9, 32'h1234));
    vecs.push_back(mk(0, 1, 32'hC1,   12, 1, 0,   1, 1, 1, 32'hC1,   12, 1, 1, 9, 32'h1234));
    vecs.push_back(mk(1, 1, 32'hC2,   13, 1, 1,   0, 0, 1, 32'hC1,   12, 1, 1, 12, 32'hC1));
    vecs.push_back(mk(0, 1, 32'hE1,   14, 0, 1,   1, 1, 1, 32'hE1,   14, 0, 1, 12, 32'hC1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 0, 1,   0, 0, 1, 32'hE1,   14, 0, 1, 12, 32'hC1));

    // Reset held with a pending input: nothing may be captured
    reset_n      = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b1;
    in_data      = 32'h55;
    in_rd        = 5'd3;
    in_reg_write = 1'b1;
    out_ready    = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    #2;
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].w, vecs[i].ordy);
      compareObs($sformatf("vec%0d", i), obs_s, vecs[i].exp);
    end

    // Randomised traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      logic [AW-1:0] r;
      r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), $urandom,
                    r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6));
    end

    // Reset asserted mid-transfer with the skid entry full
    applyStimulus(0, 1, 32'hF1, 5'd1, 1, 0);
    applyStimulus(0, 1, 32'hF2, 5'd2, 1, 0);
    applyStimulus(0, 1, 32'hF3, 5'd3, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    applyStimulus(0, 1, 32'hF4, 5'd4, 1, 1);
    cmp("post_reset.out_data", 64'(od_s), 64'h0F4);
    applyStimulus(0, 0, 32'h0, 5'd0, 0, 1);
    cmp("post_reset.fwd_data", 64'(fd_s), 64'h0F4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
